// File: rtl/uart_tx_fifo_if.sv
// +----------------------------------------------------------------------------+
// | uart_tx_fifo_if : bus-side handshake, line configuration and status of the |
// | buffered UART transmitter.                   Revision 1.0                  |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
);
  localparam int c_LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  data_ready;
  logic                  par_en;
  logic                  par_typ;
  logic                  stop2;
  logic [DIV_WIDTH-1:0]  baud_div;
  logic                  tx_out;
  logic                  busy;
  logic [c_LW-1:0]       fifo_level;

  modport master (
    output p_data, data_valid, par_en, par_typ, stop2, baud_div,
    input  data_ready, tx_out, busy, fifo_level
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, stop2, baud_div,
    output data_ready, tx_out, busy, fifo_level
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | uart_tx_fifo : FIFO-buffered UART transmitter with runtime parity, stop    |
// | bits and baud prescaler.                     Revision 1.0                  |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_LW-1:0] c_FULL = c_LW'(FIFO_DEPTH);
  localparam logic [c_BW-1:0] c_LAST = c_BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]       r_wr;
  logic [c_AW-1:0]       r_rd;
  logic [c_LW-1:0]       r_level;

  state_t                r_state;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [c_BW-1:0]       r_bit;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_stop2;
  logic                  r_stop_second;
  logic                  r_tx;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_tick;
  logic w_frame_end;
  logic w_pop;

  assign w_full      = (r_level == c_FULL);
  assign w_empty     = (r_level == '0);
  assign w_push      = bus.data_valid & ~w_full;
  assign w_tick      = (r_cnt == '0);
  assign w_frame_end = (r_state == S_STOP) && w_tick && (!r_stop2 || r_stop_second);
  // The head is taken either from idle or straight out of the last stop bit.
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_frame_end);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= bus.p_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + c_AW'(1);
      if (w_pop)  r_rd <= r_rd + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LW'(1);
        2'b01:   r_level <= r_level - c_LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_div         <= '0;
      r_bit         <= '0;
      r_data        <= '0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_stop2       <= 1'b0;
      r_stop_second <= 1'b0;
      r_tx          <= 1'b1;
    end else begin
      // Line level follows the state one cycle later, keeping the pin glitch-free.
      case (r_state)
        S_START:  r_tx <= 1'b0;
        S_DATA:   r_tx <= r_data[r_bit];
        S_PARITY: r_tx <= (^r_data) ^ r_par_typ;
        default:  r_tx <= 1'b1;
      endcase

      if (w_pop) begin
        r_data        <= r_mem[r_rd];
        r_par_en      <= bus.par_en;
        r_par_typ     <= bus.par_typ;
        r_stop2       <= bus.stop2;
        r_div         <= bus.baud_div;
        r_cnt         <= bus.baud_div;
        r_stop_second <= 1'b0;
        r_state       <= S_START;
      end else if (r_state != S_IDLE) begin
        if (!w_tick) begin
          r_cnt <= r_cnt - DIV_WIDTH'(1);
        end else begin
          r_cnt <= r_div;
          case (r_state)
            S_START: begin
              r_bit   <= '0;
              r_state <= S_DATA;
            end
            S_DATA: begin
              if (r_bit == c_LAST) begin
                r_stop_second <= 1'b0;
                r_state       <= r_par_en ? S_PARITY : S_STOP;
              end else begin
                r_bit <= r_bit + c_BW'(1);
              end
            end
            S_PARITY: begin
              r_stop_second <= 1'b0;
              r_state       <= S_STOP;
            end
            S_STOP: begin
              if (r_stop2 && !r_stop_second) begin
                r_stop_second <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.tx_out     = r_tx;
  assign bus.busy       = (r_state != S_IDLE) || !w_empty;
  assign bus.data_ready = ~w_full;
  assign bus.fifo_level = r_level;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_fifo : frame-level reference model plus directed vectors for    |
// | the buffered UART transmitter.               Revision 1.0                  |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) bus ();

  uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus the expected line samples of the frame
  // being sent, built bit by bit from the configuration seen at the pop.
  logic [DW-1:0] mq[$];
  bit            line[$];
  int            rem = 0;
  bit            m_tx = 1'b1;
  bit            m_busy = 1'b0;
  int            m_level = 0;

  task automatic add_bits(input bit b, input int n);
    repeat (n) line.push_back(b);
  endtask

  always @(posedge clk or posedge rst) begin : model
    int            sz;
    bit            rdy;
    bit            pop;
    logic [DW-1:0] w;
    int            per;
    if (rst) begin
      mq.delete();
      line.delete();
      rem     = 0;
      m_tx    = 1'b1;
      m_busy  = 1'b0;
      m_level = 0;
    end else begin
      sz   = mq.size();
      rdy  = (sz != DEPTH);
      pop  = (rem <= 1) && (sz > 0);
      m_tx = (line.size() > 0) ? line.pop_front() : 1'b1;
      if (pop) begin
        w   = mq.pop_front();
        per = int'(bus.baud_div) + 1;
        add_bits(1'b0, per);
        for (int i = 0; i < DW; i++) add_bits(w[i], per);
        if (bus.par_en) add_bits((^w) ^ bus.par_typ, per);
        add_bits(1'b1, per);
        if (bus.stop2) add_bits(1'b1, per);
        rem = (2 + DW + int'(bus.par_en) + int'(bus.stop2)) * per;
      end else if (rem > 0) begin
        rem--;
      end
      if (bus.data_valid && rdy) mq.push_back(bus.p_data);
      m_level = mq.size();
      m_busy  = (rem > 0) || (m_level > 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_out", bus.tx_out, m_tx);
      check("busy", bus.busy, m_busy);
      check("fifo_level", bus.fifo_level, m_level);
      check("data_ready", bus.data_ready, m_level != DEPTH);
    end
  end

  task automatic push(input logic [DW-1:0] d);
    @(negedge clk);
    bus.p_data     = d;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq;
    logic       s[44];
    int         lows;
    int         idx;

    bus.p_data     = '0;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.stop2      = 1'b0;
    bus.baud_div   = '0;

    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx_out, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.data_ready, 1'b1);
    check("rst_level", bus.fifo_level, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // 8N1, one cycle per bit
    push(8'hA5);
    @(negedge clk);
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seq = {seq[8:0], bus.tx_out};
    end
    check("t2_seq", seq, 10'b0101001011);
    check("t2_busy_end", bus.busy, 1'b0);
    wait_idle(50);

    // 8E1 then 8O1, four cycles per bit; 0x07 has odd weight
    for (int typ = 0; typ < 2; typ++) begin
      bus.par_en   = 1'b1;
      bus.par_typ  = typ[0];
      bus.baud_div = 16'd3;
      push(8'h07);
      @(negedge clk);
      for (int i = 0; i < 44; i++) begin
        @(negedge clk);
        s[i] = bus.tx_out;
      end
      check("t3_start_last", s[3], 1'b0);
      check("t3_bit0_first", s[4], 1'b1);
      check("t3_bit7_last", s[35], 1'b0);
      check("t3_par_first", s[36], (typ == 0) ? 1'b1 : 1'b0);
      check("t3_par_last", s[39], (typ == 0) ? 1'b1 : 1'b0);
      check("t3_stop", s[40], 1'b1);
      wait_idle(100);
    end

    // 8N2, two cycles per bit, all-zero data
    bus.par_en   = 1'b0;
    bus.stop2    = 1'b1;
    bus.baud_div = 16'd1;
    push(8'h00);
    @(negedge clk);
    lows = 0;
    idx  = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.tx_out == 1'b0) lows++;
      if (!bus.busy && idx < 0) idx = i;
    end
    check("t4_low_cycles", lows, 18);
    check("t4_busy_fall", idx, 21);
    wait_idle(100);

    // Six back-to-back pushes: one popped, four stored, last dropped
    bus.stop2    = 1'b0;
    bus.baud_div = 16'd0;
    @(negedge clk);
    bus.data_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.p_data = 8'h10 + 8'(k);
      @(negedge clk);
      if (k == 4) begin
        check("t5_level_full", bus.fifo_level, 4);
        check("t5_ready_low", bus.data_ready, 1'b0);
      end
    end
    bus.data_valid = 1'b0;
    check("t5_level_after_drop", bus.fifo_level, 4);
    wait_idle(200);

    // Config change during DATA applies only to the following frame
    bus.baud_div = 16'd1;
    push(8'h3C);
    repeat (6) @(negedge clk);
    bus.par_en   = 1'b1;
    bus.par_typ  = 1'b1;
    bus.baud_div = 16'd2;
    push(8'hC3);
    wait_idle(200);

    // Asynchronous reset in the middle of a start bit
    bus.par_en   = 1'b0;
    bus.baud_div = 16'd3;
    push(8'h00);
    repeat (4) @(negedge clk);
    check("t1_pre_low", bus.tx_out, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t1_async_tx", bus.tx_out, 1'b1);
    check("t1_async_busy", bus.busy, 1'b0);
    check("t1_async_level", bus.fifo_level, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    bus.baud_div = 16'd0;
    push(8'h5A);
    wait_idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
